// File: rtl/crosshair_pkg.sv
// Shared types and constants for the crosshair overlay mixer: pixel/coordinate
// typedefs, default screen limits and the span test used by the hit compare.
package crosshair_pkg;

  localparam int PIX_W = 8;

  typedef logic [9:0] coord_t;

  typedef struct packed {
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
  } rgb_t;

  localparam int   DEF_X_MAX = 639;
  localparam int   DEF_Y_MAX = 479;
  localparam rgb_t RGB_WHITE = '{r: '1, g: '1, b: '1};

  // Signed 11-bit so c-arm never wraps below zero near the screen edge.
  function automatic logic in_span(input coord_t p, input coord_t c, input int arm);
    logic signed [10:0] ps;
    logic signed [10:0] lo;
    logic signed [10:0] hi;
    ps = $signed({1'b0, p});
    lo = $signed({1'b0, c}) - $signed(11'(arm));
    hi = $signed({1'b0, c}) + $signed(11'(arm));
    return (ps >= lo) && (ps <= hi);
  endfunction

endpackage

// File: rtl/cursor_position_ctrl.sv
// Cursor centre with per-frame saturating moves, plus the run-mode blink
// counter and crosshair visibility flag.
module cursor_position_ctrl
  import crosshair_pkg::*;
#(
  parameter int X_MAX        = DEF_X_MAX,
  parameter int Y_MAX        = DEF_Y_MAX,
  parameter int ARM_LEN      = 10,
  parameter int INIT_X       = 464,
  parameter int INIT_Y       = 274,
  parameter int STEP         = 2,
  parameter int BLINK_FRAMES = 30
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   frame_start,
  input  logic   run,
  input  logic   move_left,
  input  logic   move_right,
  input  logic   move_up,
  input  logic   move_down,
  output coord_t cur_x,
  output coord_t cur_y,
  output logic   visible
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  coord_t           cur_x_q, cur_x_d;
  coord_t           cur_y_q, cur_y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             visible_q, visible_d;

  function automatic coord_t step_up(input coord_t c, input int hi);
    logic [10:0] s;
    s = {1'b0, c} + 11'(STEP);
    return (s > 11'(hi)) ? coord_t'(hi) : s[9:0];
  endfunction

  function automatic coord_t step_dn(input coord_t c);
    return ({1'b0, c} < 11'(ARM_LEN + STEP)) ? coord_t'(ARM_LEN) : c - coord_t'(STEP);
  endfunction

  always_comb begin
    cur_x_d   = cur_x_q;
    cur_y_d   = cur_y_q;
    cnt_d     = cnt_q;
    visible_d = visible_q;
    if (frame_start) begin
      if (move_right && !move_left)      cur_x_d = step_up(cur_x_q, X_MAX - ARM_LEN);
      else if (move_left && !move_right) cur_x_d = step_dn(cur_x_q);
      if (move_down && !move_up)         cur_y_d = step_up(cur_y_q, Y_MAX - ARM_LEN);
      else if (move_up && !move_down)    cur_y_d = step_dn(cur_y_q);
    end
    if (!run) begin
      cnt_d     = '0;
      visible_d = 1'b1;
    end else if (frame_start) begin
      if (cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
        cnt_d     = '0;
        visible_d = ~visible_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_x_q   <= coord_t'(INIT_X);
      cur_y_q   <= coord_t'(INIT_Y);
      cnt_q     <= '0;
      visible_q <= 1'b1;
    end else begin
      cur_x_q   <= cur_x_d;
      cur_y_q   <= cur_y_d;
      cnt_q     <= cnt_d;
      visible_q <= visible_d;
    end
  end

  assign cur_x   = cur_x_q;
  assign cur_y   = cur_y_q;
  assign visible = visible_q;

endmodule

// File: rtl/crosshair_overlay_mixer.sv
// Registered camera/memory-box/crosshair pixel mixer with cursor capture handshake.
// CROSSHAIR_INVERT_EN: crosshair pixels show the inverted camera pixel instead of CURSOR_RGB.
module crosshair_overlay_mixer
  import crosshair_pkg::*;
#(
  parameter int          IN_W         = 10,
  parameter int          OUT_W        = 8,
  parameter int          X_MAX        = DEF_X_MAX,
  parameter int          Y_MAX        = DEF_Y_MAX,
  parameter int          ARM_LEN      = 10,
  parameter int          INIT_X       = 464,
  parameter int          INIT_Y       = 274,
  parameter int          STEP         = 2,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [23:0] CURSOR_RGB   = 24'hFFFFFF
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [IN_W-1:0]  VGA_R_In,
  input  logic [IN_W-1:0]  VGA_G_In,
  input  logic [IN_W-1:0]  VGA_B_In,
  input  logic [9:0]       VGA_X,
  input  logic [9:0]       VGA_Y,
  input  logic             frame_start,
  input  logic             memory_on,
  input  logic             run,
  input  logic             move_left,
  input  logic             move_right,
  input  logic             move_up,
  input  logic             move_down,
  input  logic             capture,
  input  logic             cap_ack,
  output logic [OUT_W-1:0] VGA_R,
  output logic [OUT_W-1:0] VGA_G,
  output logic [OUT_W-1:0] VGA_B,
  output logic [9:0]       cur_x,
  output logic [9:0]       cur_y,
  output logic [9:0]       cap_x,
  output logic [9:0]       cap_y,
  output logic             cap_valid
);

  coord_t cur_x_w, cur_y_w;
  logic   visible;

  cursor_position_ctrl #(
    .X_MAX(X_MAX), .Y_MAX(Y_MAX), .ARM_LEN(ARM_LEN), .INIT_X(INIT_X),
    .INIT_Y(INIT_Y), .STEP(STEP), .BLINK_FRAMES(BLINK_FRAMES)
  ) u_cursor (
    .clk(CLK), .rst(Reset), .frame_start(frame_start), .run(run),
    .move_left(move_left), .move_right(move_right),
    .move_up(move_up), .move_down(move_down),
    .cur_x(cur_x_w), .cur_y(cur_y_w), .visible(visible)
  );

  logic [OUT_W-1:0] cam_r, cam_g, cam_b;
  logic [OUT_W-1:0] xh_r, xh_g, xh_b;
  logic             hit;

  assign cam_r = VGA_R_In[IN_W-1 -: OUT_W];
  assign cam_g = VGA_G_In[IN_W-1 -: OUT_W];
  assign cam_b = VGA_B_In[IN_W-1 -: OUT_W];

  generate
    if (IN_W > OUT_W) begin : g_trunc
      logic unused_lsbs;
      assign unused_lsbs = ^{VGA_R_In[IN_W-OUT_W-1:0], VGA_G_In[IN_W-OUT_W-1:0],
                             VGA_B_In[IN_W-OUT_W-1:0]};
    end
  endgenerate

`ifdef CROSSHAIR_INVERT_EN
  assign xh_r = ~cam_r;
  assign xh_g = ~cam_g;
  assign xh_b = ~cam_b;
`else
  // Colour bytes are MSB-aligned into OUT_W, so narrower outputs keep the top bits.
  localparam rgb_t             CURSOR_BYTES = rgb_t'(CURSOR_RGB);
  localparam logic [OUT_W+7:0] CUR_R_EXT    = {CURSOR_BYTES.r, {OUT_W{1'b0}}};
  localparam logic [OUT_W+7:0] CUR_G_EXT    = {CURSOR_BYTES.g, {OUT_W{1'b0}}};
  localparam logic [OUT_W+7:0] CUR_B_EXT    = {CURSOR_BYTES.b, {OUT_W{1'b0}}};
  assign xh_r = CUR_R_EXT[OUT_W+7 -: OUT_W];
  assign xh_g = CUR_G_EXT[OUT_W+7 -: OUT_W];
  assign xh_b = CUR_B_EXT[OUT_W+7 -: OUT_W];
`endif

  assign hit = ((VGA_Y == cur_y_w) && in_span(VGA_X, cur_x_w, ARM_LEN)) ||
               ((VGA_X == cur_x_w) && in_span(VGA_Y, cur_y_w, ARM_LEN));

  logic [OUT_W-1:0] out_r_q, out_r_d, out_g_q, out_g_d, out_b_q, out_b_d;
  coord_t           cap_x_q, cap_x_d, cap_y_q, cap_y_d;
  logic             cap_valid_q, cap_valid_d;

  always_comb begin
    out_r_d = cam_r;
    out_g_d = cam_g;
    out_b_d = cam_b;
    if (hit && visible) begin
      out_r_d = xh_r;
      out_g_d = xh_g;
      out_b_d = xh_b;
    end else if (memory_on) begin
      out_r_d = '1;
      out_g_d = '1;
      out_b_d = '1;
    end
  end

  // A capture that coincides with the ack replaces the pending sample.
  always_comb begin
    cap_x_d     = cap_x_q;
    cap_y_d     = cap_y_q;
    cap_valid_d = cap_valid_q;
    if (capture && (!cap_valid_q || cap_ack)) begin
      cap_x_d     = cur_x_w;
      cap_y_d     = cur_y_w;
      cap_valid_d = 1'b1;
    end else if (cap_ack) begin
      cap_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      out_r_q     <= '0;
      out_g_q     <= '0;
      out_b_q     <= '0;
      cap_x_q     <= '0;
      cap_y_q     <= '0;
      cap_valid_q <= 1'b0;
    end else begin
      out_r_q     <= out_r_d;
      out_g_q     <= out_g_d;
      out_b_q     <= out_b_d;
      cap_x_q     <= cap_x_d;
      cap_y_q     <= cap_y_d;
      cap_valid_q <= cap_valid_d;
    end
  end

  assign VGA_R     = out_r_q;
  assign VGA_G     = out_g_q;
  assign VGA_B     = out_b_q;
  assign cur_x     = cur_x_w;
  assign cur_y     = cur_y_w;
  assign cap_x     = cap_x_q;
  assign cap_y     = cap_y_q;
  assign cap_valid = cap_valid_q;

endmodule

// File: tb/tb_crosshair_overlay_mixer.sv
// Self-checking bench for crosshair_overlay_mixer: table-driven pixel vectors with
// a scoreboard queue, plus sequences for movement, blink, capture and async reset.
module tb_crosshair_overlay_mixer;

  logic       CLK = 1'b0;
  logic       Reset = 1'b0;
  logic [9:0] VGA_R_In = '0, VGA_G_In = '0, VGA_B_In = '0;
  logic [9:0] VGA_X = '0, VGA_Y = '0;
  logic       frame_start = 0, memory_on = 0, run = 0;
  logic       move_left = 0, move_right = 0, move_up = 0, move_down = 0;
  logic       capture = 0, cap_ack = 0;
  logic [7:0] VGA_R, VGA_G, VGA_B;
  logic [9:0] cur_x, cur_y, cap_x, cap_y;
  logic       cap_valid;

  crosshair_overlay_mixer dut (
    .CLK(CLK), .Reset(Reset),
    .VGA_R_In(VGA_R_In), .VGA_G_In(VGA_G_In), .VGA_B_In(VGA_B_In),
    .VGA_X(VGA_X), .VGA_Y(VGA_Y), .frame_start(frame_start), .memory_on(memory_on),
    .run(run), .move_left(move_left), .move_right(move_right),
    .move_up(move_up), .move_down(move_down), .capture(capture), .cap_ack(cap_ack),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .cur_x(cur_x), .cur_y(cur_y), .cap_x(cap_x), .cap_y(cap_y), .cap_valid(cap_valid)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [23:0] sb_q[$];

  typedef struct {
    logic [9:0]  x, y;
    logic [9:0]  r, g, b;
    logic        mem;
    logic        xh;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs[14];

  function automatic logic [7:0] xh_col(input logic [9:0] cam);
`ifdef CROSSHAIR_INVERT_EN
    return ~cam[9:2];
`else
    return 8'hFF;
`endif
  endfunction

  function automatic logic [23:0] xh_rgb(input logic [9:0] r, input logic [9:0] g,
                                         input logic [9:0] b);
    return {xh_col(r), xh_col(g), xh_col(b)};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s value=%0h", name, act);
    end
  endtask

  task automatic pix(input string name, input logic [9:0] x, input logic [9:0] y,
                     input logic [9:0] r, input logic [9:0] g, input logic [9:0] b,
                     input logic mem, input logic [23:0] exp);
    logic [23:0] want;
    VGA_X = x; VGA_Y = y; VGA_R_In = r; VGA_G_In = g; VGA_B_In = b; memory_on = mem;
    sb_q.push_back(exp);
    tick();
    if (sb_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s scoreboard empty", name);
    end else begin
      want = sb_q.pop_front();
      chk(name, {8'h0, VGA_R, VGA_G, VGA_B}, {8'h0, want});
    end
    memory_on = 0;
  endtask

  task automatic frame(input logic l, input logic r, input logic u, input logic d);
    move_left = l; move_right = r; move_up = u; move_down = d; frame_start = 1;
    tick();
    frame_start = 0; move_left = 0; move_right = 0; move_up = 0; move_down = 0;
  endtask

  task automatic do_reset();
    Reset = 1;
    tick();
    Reset = 0;
    tick();
  endtask

  initial begin
    // {x, y, r, g, b, mem, xh, exp}; xh rows get the crosshair colour of their camera pixel
    vecs[0]  = '{464, 274, 10'h3FC, 10'h3FC, 10'h3FC, 0, 1, 24'h0};
    vecs[1]  = '{470, 280, 10'h3FC, 10'h3FC, 10'h3FC, 0, 0, 24'hFFFFFF};
    vecs[2]  = '{470, 280, 10'h200, 10'h200, 10'h200, 0, 0, 24'h808080};
    vecs[3]  = '{474, 274, 10'h200, 10'h200, 10'h200, 0, 1, 24'h0};
    vecs[4]  = '{475, 274, 10'h200, 10'h200, 10'h200, 0, 0, 24'h808080};
    vecs[5]  = '{454, 274, 10'h200, 10'h200, 10'h200, 0, 1, 24'h0};
    vecs[6]  = '{453, 274, 10'h200, 10'h200, 10'h200, 0, 0, 24'h808080};
    vecs[7]  = '{464, 264, 10'h200, 10'h200, 10'h200, 0, 1, 24'h0};
    vecs[8]  = '{464, 263, 10'h200, 10'h200, 10'h200, 0, 0, 24'h808080};
    vecs[9]  = '{464, 284, 10'h200, 10'h200, 10'h200, 0, 1, 24'h0};
    vecs[10] = '{464, 285, 10'h200, 10'h200, 10'h200, 0, 0, 24'h808080};
    vecs[11] = '{100, 100, 10'h200, 10'h200, 10'h200, 1, 0, 24'hFFFFFF};
    vecs[12] = '{464, 274, 10'h0C0, 10'h0C0, 10'h0C0, 1, 1, 24'h0};
    vecs[13] = '{0,   0,   10'h3FC, 10'h200, 10'h004, 0, 0, 24'hFF8001};

    // Reset state
    #1 Reset = 1;
    #1;
    chk("reset_rgb", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h0);
    chk("reset_cur_x", cur_x, 464);
    chk("reset_cur_y", cur_y, 274);
    chk("reset_cap", {cap_valid, cap_x, cap_y}, 0);
    tick();
    Reset = 0;
    tick();

    // Pixel mixing table
    for (int i = 0; i < 14; i++) begin
      pix($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].r, vecs[i].g, vecs[i].b,
          vecs[i].mem,
          vecs[i].xh ? xh_rgb(vecs[i].r, vecs[i].g, vecs[i].b) : vecs[i].exp);
    end

    // Movement: only on frame_start, STEP per frame, saturating
    move_right = 1;
    tick(); tick();
    move_right = 0;
    chk("no_move_without_frame", cur_x, 464);
    for (int i = 0; i < 3; i++) frame(0, 1, 0, 0);
    chk("move_right_3", cur_x, 470);
    pix("xh_follows_cursor", 470, 274, 10'h200, 10'h200, 10'h200, 0,
        xh_rgb(10'h200, 10'h200, 10'h200));
    pix("old_arm_gone", 459, 274, 10'h200, 10'h200, 10'h200, 0, 24'h808080);
    frame(1, 1, 0, 0);
    chk("both_lr_hold", cur_x, 470);
    frame(0, 1, 1, 0);
    chk("diag_x", cur_x, 472);
    chk("diag_y", cur_y, 272);
    for (int i = 0; i < 230; i++) frame(1, 0, 0, 0);
    chk("left_to_12", cur_x, 12);
    frame(1, 0, 0, 0);
    chk("left_sat_10", cur_x, 10);
    frame(1, 0, 0, 0);
    chk("left_stays_10", cur_x, 10);
    for (int i = 0; i < 100; i++) frame(0, 0, 0, 1);
    chk("down_sat_469", cur_y, 469);
    frame(0, 0, 1, 1);
    chk("both_ud_hold", cur_y, 469);

    // Blink in run mode
    do_reset();
    run = 1;
    tick();
    for (int f = 0; f < 90; f++) begin
      pix($sformatf("blink_f%0d", f), 464, 274, 10'h200, 10'h200, 10'h200, 0,
          (((f / 30) % 2) == 0) ? xh_rgb(10'h200, 10'h200, 10'h200) : 24'h808080);
      frame(0, 0, 0, 0);
    end
    run = 0;
    pix("run_drop_same_cycle", 464, 274, 10'h200, 10'h200, 10'h200, 0, 24'h808080);
    pix("run_drop_next_cycle", 464, 274, 10'h200, 10'h200, 10'h200, 0,
        xh_rgb(10'h200, 10'h200, 10'h200));

    // Capture handshake
    do_reset();
    capture = 1; tick(); capture = 0;
    chk("cap1_valid", cap_valid, 1);
    chk("cap1_xy", {cap_x, cap_y}, {10'd464, 10'd274});
    frame(0, 1, 0, 0);
    capture = 1; tick(); capture = 0;
    chk("cap_pending_hold", {cap_valid, cap_x, cap_y}, {1'b1, 10'd464, 10'd274});
    cap_ack = 1; tick(); cap_ack = 0;
    chk("cap_ack_clear", cap_valid, 0);
    capture = 1; tick(); capture = 0;
    chk("cap2_x", cap_x, 466);
    frame(0, 1, 0, 0);
    capture = 1; cap_ack = 1; tick(); capture = 0; cap_ack = 0;
    chk("cap_ack_same_cycle", {cap_valid, cap_x}, {1'b1, 10'd468});
    cap_ack = 1; tick(); tick(); cap_ack = 0;
    chk("ack_idle_noop", {cap_valid, cap_x}, {1'b0, 10'd468});
    capture = 1; move_right = 1; frame_start = 1;
    tick();
    capture = 0; move_right = 0; frame_start = 0;
    chk("cap_on_frame_pre", cap_x, 468);
    chk("cur_after_frame", cur_x, 470);

    // Async reset mid-line, no clock edge
    for (int i = 0; i < 15; i++) frame(0, 1, 0, 0);
    chk("pre_reset_cur_x", cur_x, 500);
    pix("pre_reset_pix", 100, 100, 10'h200, 10'h200, 10'h200, 1, 24'hFFFFFF);
    #2 Reset = 1;
    #1;
    chk("async_rst_rgb", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h0);
    chk("async_rst_cur", {cur_x, cur_y}, {10'd464, 10'd274});
    chk("async_rst_cap", {cap_valid, cap_x, cap_y}, 0);
    tick();
    Reset = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
